// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling engine.
// RC4_KSA_INIT_EN adds the INIT_S identity-fill pass in front of the shuffle.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT_S,
    RD_I,
    WT_I,
    CALC_J,
    RD_J,
    WT_J,
    WR_J,
    WR_I,
    DONE
  } state_t;

  localparam int KEY_W      = 8;
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/rc4_key_sel.sv
// Latched secret key plus wrapping byte index; presents the current key byte.
// Byte 0 of the key lives in the most significant bits of key_in.
module rc4_key_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       adv,
  input  logic [KEY_W*KEY_BYTES-1:0] key_in,
  output logic [KEY_W-1:0]           key_byte
);

  localparam int KIW =
    (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIW-1:0] KLAST =
    KIW'(KEY_BYTES - 1);

  logic [KEY_W*KEY_BYTES-1:0] key_q;
  logic [KIW-1:0]             kidx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      kidx  <= '0;
    end else if (load) begin
      key_q <= key_in;
      kidx  <= '0;
    end else if (adv) begin
      kidx <= (kidx == KLAST) ? '0 : kidx + 1'b1;
    end
  end

  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (kidx == KIW'(k))
        key_byte = key_q[KEY_W*(KEY_BYTES-1-k) +: KEY_W];
    end
  end

endmodule

// File: rtl/rc4_ksa_shuffle.sv
// RC4 KSA swap engine driving a single-port S RAM with RD_LAT read latency.
// Define RC4_KSA_INIT_EN to fill S[i]=i in-engine before the shuffle.
module rc4_ksa_shuffle
  import rc4_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [8*KEY_BYTES-1:0]     key_in,
  input  logic [ADDR_W-1:0]          mem_rdata,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [ADDR_W-1:0]          mem_wdata,
  output logic                       mem_we,
  output logic                       busy,
  output logic                       done
);

  localparam logic [ADDR_W-1:0] I_MAX  = '1;
  localparam logic [1:0]        W_LAST = 2'(RD_LAT - 1);

  state_t              state;
  logic [ADDR_W-1:0]   i;
  logic [ADDR_W-1:0]   j;
  logic [ADDR_W-1:0]   si;
  logic [ADDR_W-1:0]   sj;
  logic [1:0]          wcnt;
  logic [KEY_W-1:0]    key_byte;
  logic [ADDR_W-1:0]   key_a;
  logic [ADDR_W-1:0]   j_next;
  logic                load;
  logic                adv;

  assign load = start && (state == IDLE || state == DONE);
  assign adv  = (state == WR_I) && (i != I_MAX);

  rc4_key_sel #(
    .KEY_BYTES (KEY_BYTES)
  ) u_key_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .adv      (adv),
    .key_in   (key_in),
    .key_byte (key_byte)
  );

  // key byte is zero-extended or truncated to the S-box data width
  assign key_a  = ADDR_W'(key_byte);
  assign j_next = j + si + key_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      si        <= '0;
      sj        <= '0;
      wcnt      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            i        <= '0;
            j        <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            mem_addr <= '0;
`ifdef RC4_KSA_INIT_EN
            state     <= INIT_S;
            mem_wdata <= '0;
            mem_we    <= 1'b1;
`else
            state  <= RD_I;
            mem_we <= 1'b0;
`endif
          end
        end
`ifdef RC4_KSA_INIT_EN
        INIT_S: begin
          if (i == I_MAX) begin
            i        <= '0;
            mem_addr <= '0;
            mem_we   <= 1'b0;
            state    <= RD_I;
          end else begin
            i         <= i + 1'b1;
            mem_addr  <= i + 1'b1;
            mem_wdata <= i + 1'b1;
            mem_we    <= 1'b1;
          end
        end
`endif
        RD_I: begin
          wcnt  <= '0;
          state <= WT_I;
        end
        WT_I: begin
          if (wcnt == W_LAST) begin
            si    <= mem_rdata;
            state <= CALC_J;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        CALC_J: begin
          j        <= j_next;
          mem_addr <= j_next;
          state    <= RD_J;
        end
        RD_J: begin
          wcnt  <= '0;
          state <= WT_J;
        end
        WT_J: begin
          if (wcnt == W_LAST) begin
            sj        <= mem_rdata;
            mem_wdata <= si;
            mem_we    <= 1'b1;
            state     <= WR_J;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        WR_J: begin
          mem_addr  <= i;
          mem_wdata <= sj;
          mem_we    <= 1'b1;
          state     <= WR_I;
        end
        WR_I: begin
          mem_we <= 1'b0;
          if (i == I_MAX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i        <= i + 1'b1;
            mem_addr <= i + 1'b1;
            state    <= RD_I;
          end
        end
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
